// File: rtl/mem_walker_pkg.sv
// Shared widths, event encoding and helpers for the stride memory walker.
package mem_walker_pkg;

  localparam int ADDR_WIDTH_DEF    = 48;
  localparam int ADDR_STRIDE_W_DEF = 16;
  localparam int LOOP_ID_W_DEF     = 5;
  localparam int NUM_LOOPS_DEF     = 8;
  localparam int ROW_LEN_W_DEF     = 16;

  // Widest operand the sign-extension helper handles; addresses must fit.
  localparam int SEXT_W = 64;

  // One action per cycle, resolved in this priority order.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_INIT,
    EV_EXIT,
    EV_STEP,
    EV_ENTER
  } ev_e;

  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                             input int unsigned       w);
    logic [SEXT_W-1:0] r;
    r = v;
    for (int i = 0; i < SEXT_W; i++) begin
      if (i >= int'(w)) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_walker_stride_table.sv
// Per-loop-level stride register file, filled sequentially by a write pointer.
module mem_walker_stride_table
  import mem_walker_pkg::*;
#(
  parameter int ADDR_STRIDE_W = ADDR_STRIDE_W_DEF,
  parameter int LOOP_ID_W     = LOOP_ID_W_DEF,
  parameter int NUM_LOOPS     = NUM_LOOPS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_v_i,
  input  logic [ADDR_STRIDE_W-1:0] wr_data_i,
  input  logic                     rewind_i,
  input  logic [LOOP_ID_W-1:0]     rd_idx_i,
  output logic [ADDR_STRIDE_W-1:0] rd_data_o,
  output logic                     ovf_o
);

  localparam int PTR_W = $clog2(NUM_LOOPS + 1);

  logic [NUM_LOOPS-1:0][ADDR_STRIDE_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d;
  logic                                    full;

  assign full  = (wr_ptr_q == PTR_W'(NUM_LOOPS));
  assign ovf_o = wr_v_i && full;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_v_i && !full) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (wr_ptr_q == PTR_W'(i)) mem_d[i] = wr_data_i;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    // A rewind in the same cycle as a write still lets the write land first.
    if (rewind_i) wr_ptr_d = '0;
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (rd_idx_i == LOOP_ID_W'(i)) rd_data_o = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/mem_walker_stride_wrap.sv
// Stride memory walker: one address per loop step, with runtime row/channel wrap,
// signed strides, per-level entry-point save/restore and sticky error flag.
module mem_walker_stride_wrap
  import mem_walker_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int ADDR_STRIDE_W = ADDR_STRIDE_W_DEF,
  parameter int LOOP_ID_W     = LOOP_ID_W_DEF,
  parameter int NUM_LOOPS     = NUM_LOOPS_DEF,
  parameter int ROW_LEN_W     = ROW_LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     loop_ctrl_done,
  input  logic [LOOP_ID_W-1:0]     loop_index,
  input  logic                     loop_index_valid,
  input  logic                     loop_init,
  input  logic                     loop_enter,
  input  logic                     loop_exit,
  input  logic                     cfg_addr_stride_v,
  input  logic [ADDR_STRIDE_W-1:0] cfg_addr_stride,
  input  logic                     cfg_wrap_v,
  input  logic [ROW_LEN_W-1:0]     cfg_row_len,
  input  logic [ADDR_WIDTH-1:0]    cfg_chnl_stride,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     addr_out_valid,
  output logic                     cfg_err
);

  localparam int IDW1 = LOOP_ID_W + 1;

  logic [ADDR_STRIDE_W-1:0] stride_rd;
  logic                     stride_ovf;

  mem_walker_stride_table #(
    .ADDR_STRIDE_W (ADDR_STRIDE_W),
    .LOOP_ID_W     (LOOP_ID_W),
    .NUM_LOOPS     (NUM_LOOPS)
  ) u_stride_table (
    .clk       (clk),
    .reset     (reset),
    .wr_v_i    (cfg_addr_stride_v),
    .wr_data_i (cfg_addr_stride),
    .rewind_i  (loop_ctrl_done),
    .rd_idx_i  (loop_index),
    .rd_data_o (stride_rd),
    .ovf_o     (stride_ovf)
  );

  logic [NUM_LOOPS-1:0][ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] chnl_base_q, chnl_base_d;
  logic [ADDR_WIDTH-1:0] chnl_stride_q, chnl_stride_d;
  logic [ROW_LEN_W-1:0]  row_len_q, row_len_d;
  logic [ROW_LEN_W-1:0]  col_cnt_q, col_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;

  logic                  idx_ok, is_lvl0, wrap_hit, proto_err;
  logic [ADDR_WIDTH-1:0] stride_ext, offset_rd, next_base;
  ev_e                   ev;

  assign idx_ok     = ({1'b0, loop_index} < IDW1'(NUM_LOOPS));
  assign is_lvl0    = (loop_index == '0);
  assign stride_ext = ADDR_WIDTH'(sext(SEXT_W'(stride_rd), ADDR_STRIDE_W));
  assign next_base  = chnl_base_q + chnl_stride_q;
  assign wrap_hit   = is_lvl0 && (row_len_q != '0) &&
                      (col_cnt_q == row_len_q - ROW_LEN_W'(1));

  // Out-of-range level or exit colliding with a step; init overrides both.
  assign proto_err = !loop_init &&
                     ((!idx_ok && (loop_exit || loop_index_valid || loop_enter)) ||
                      (loop_exit && loop_index_valid));

  always_comb begin
    ev = EV_NONE;
    if (loop_init)                       ev = EV_INIT;
    else if (loop_exit && idx_ok)        ev = EV_EXIT;
    else if (loop_index_valid && idx_ok) ev = EV_STEP;
    else if (loop_enter && idx_ok)       ev = EV_ENTER;
  end

  always_comb begin
    offset_rd = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (loop_index == LOOP_ID_W'(i)) offset_rd = offset_q[i];
    end
  end

  always_comb begin
    offset_d      = offset_q;
    cur_addr_d    = cur_addr_q;
    chnl_base_d   = chnl_base_q;
    chnl_stride_d = chnl_stride_q;
    row_len_d     = row_len_q;
    col_cnt_d     = col_cnt_q;
    addr_out_d    = addr_out_q;
    vld_d         = 1'b0;
    err_d         = err_q | stride_ovf | proto_err;

    case (ev)
      EV_INIT: begin
        cur_addr_d  = base_addr;
        chnl_base_d = base_addr;
        col_cnt_d   = '0;
        for (int i = 0; i < NUM_LOOPS; i++) offset_d[i] = base_addr;
      end
      EV_EXIT: cur_addr_d = offset_rd;
      EV_STEP: begin
        addr_out_d = cur_addr_q;
        vld_d      = 1'b1;
        if (wrap_hit) begin
          chnl_base_d = next_base;
          cur_addr_d  = next_base;
          col_cnt_d   = '0;
        end else begin
          cur_addr_d = cur_addr_q + stride_ext;
          if (is_lvl0) col_cnt_d = col_cnt_q + ROW_LEN_W'(1);
        end
      end
      EV_ENTER: begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
          if (loop_index == LOOP_ID_W'(i)) offset_d[i] = cur_addr_q;
        end
      end
      default: ;
    endcase

    if (cfg_wrap_v) begin
      row_len_d     = cfg_row_len;
      chnl_stride_d = cfg_chnl_stride;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      offset_q      <= '0;
      cur_addr_q    <= '0;
      chnl_base_q   <= '0;
      chnl_stride_q <= '0;
      row_len_q     <= '0;
      col_cnt_q     <= '0;
      addr_out_q    <= '0;
      vld_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      offset_q      <= offset_d;
      cur_addr_q    <= cur_addr_d;
      chnl_base_q   <= chnl_base_d;
      chnl_stride_q <= chnl_stride_d;
      row_len_q     <= row_len_d;
      col_cnt_q     <= col_cnt_d;
      addr_out_q    <= addr_out_d;
      vld_q         <= vld_d;
      err_q         <= err_d;
    end
  end

  assign addr_out       = addr_out_q;
  assign addr_out_valid = vld_q;
  assign cfg_err        = err_q;

endmodule

// File: doc/mem_walker_stride_wrap.md
Name: mem_walker_stride_wrap

Overview:
Parametrised next-generation stride memory walker: generates one address per loop-controller step from a per-loop-level stride table.
Adds a runtime-configurable row/channel wrap, replacing fixed-constant wrapping; when enabled, the innermost loop jumps to the next channel base after `cfg_row_len` steps.
Also adds signed strides, per-level entry-point save/restore and configuration error flagging.
Sits between the loop controller and the buffer read/load address path.

Parameters:
ADDR_WIDTH, 48, address width.
ADDR_STRIDE_W, 16, stride width (two's complement).
LOOP_ID_W, 5, loop index width.
NUM_LOOPS, 8, number of stride/offset entries; must be ≤ 2**LOOP_ID_W.
ROW_LEN_W, 16, width of the row-length and column counter.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
base_addr  in  ADDR_WIDTH  start address, sampled on loop_init.
loop_ctrl_done  in  1  end of loop program; rewinds the stride write pointer.
loop_index  in  LOOP_ID_W  loop level addressed by enter/exit/step.
loop_index_valid  in  1  step pulse for level loop_index.
loop_init  in  1  start of a new walk.
loop_enter  in  1  entering level loop_index.
loop_exit  in  1  leaving level loop_index.
cfg_addr_stride_v  in  1  stride table write strobe.
cfg_addr_stride  in  ADDR_STRIDE_W  stride value (signed).
cfg_wrap_v  in  1  wrap config strobe.
cfg_row_len  in  ROW_LEN_W  steps per row; 0 disables wrap.
cfg_chnl_stride  in  ADDR_WIDTH  channel base increment on wrap.
addr_out  out  ADDR_WIDTH  issued address.
addr_out_valid  out  1  addr_out qualifier.
cfg_err  out  1  sticky error flag.

Behaviour:
- **Reset** (reset==0 at edge):
  - addr_out=0, addr_out_valid=0, cfg_err=0.
  - All strides=0, all offsets=0, wr_ptr=0.
  - row_len=0, chnl_stride=0, cur_addr=0, chnl_base=0, col_cnt=0.
  - Reset mid-walk takes effect at the next edge; addr_out_valid is low the following cycle.
- **Stride table:**
  - cfg_addr_stride_v writes stride[wr_ptr], then wr_ptr+1.
  - If wr_ptr==NUM_LOOPS, the write is dropped and cfg_err is set.
  - loop_ctrl_done sets wr_ptr=0. If it coincides with cfg_addr_stride_v, the write lands at the old wr_ptr and wr_ptr then becomes 0.
- **Wrap config:** cfg_wrap_v latches cfg_row_len and cfg_chnl_stride. The values are unchanged by loop_ctrl_done.
- **Arithmetic:** strides are sign-extended to ADDR_WIDTH. All sums are modulo 2**ADDR_WIDTH (wrap-around, no saturation).
- **Event priority** (one action per cycle): loop_init > loop_exit > loop_index_valid > loop_enter.
- **loop_init:**
  - cur_addr=base_addr, chnl_base=base_addr, col_cnt=0.
  - All offset[i]=base_addr.
  - No output.
- **loop_enter k:** offset[k]=cur_addr. No output.
- **loop_exit k:** cur_addr=offset[k]. No output.
- **loop_index_valid k (step):**
  - Issue: the next cycle addr_out=cur_addr and addr_out_valid=1. Latency is exactly 1 cycle; otherwise addr_out_valid=0 and addr_out holds.
  - Wrap step, taken when k==0 AND row_len!=0 AND col_cnt==row_len-1: chnl_base+=chnl_stride, cur_addr=new chnl_base, col_cnt=0.
  - Normal step k==0: cur_addr+=stride[0], col_cnt+1.
  - Normal step k>0: cur_addr+=stride[k]; col_cnt unchanged.
- **Illegal events** (each sets cfg_err; cfg_err clears only on reset):
  - loop_index ≥ NUM_LOOPS with step, enter or exit: the event is ignored.
  - loop_exit and loop_index_valid in the same cycle: exit applies and the step is dropped.
- **Throughput:** back-to-back steps are supported every cycle.

Decomposition:
- Package mem_walker_pkg holds:
  - default width constants;
  - the event-priority encoding as a localparam enum (EV_NONE, EV_INIT, EV_EXIT, EV_STEP, EV_ENTER);
  - the sign-extension function.
- Sub-module mem_walker_stride_table: NUM_LOOPS×ADDR_STRIDE_W register file with write pointer, overflow detect, combinational read by loop_index.
- Offset array, wrap counter and output register stay in the top level.

Test Plan:
- **Wrap:** base 0x1000, stride[0]=4, row_len=3, chnl_stride=0x100, 7 steps at k=0 -> addr_out 0x1000,0x1004,0x1008,0x1100,0x1104,0x1108,0x1200, each valid 1 cycle after its step.
- **Negative stride:** stride[0]=0xFFFC, base 0x20, wrap off, 3 steps -> 0x20,0x1C,0x18. Base 0x0 with one extra step -> 0x0 then next issue 0xFFFF_FFFF_FFFC.
- **Nested walk:** strides[1,0x40], init base 0:
  - enter1, enter0, 3 steps k0 -> 0x0,0x1,0x2;
  - exit0, step k1 -> 0x0;
  - enter0, 2 steps k0 -> 0x40,0x41.
- **Config overflow:** NUM_LOOPS=8, 9 stride writes -> 9th dropped and cfg_err=1. Then loop_ctrl_done plus one write -> stride[0] overwritten.
- **Protocol errors:** exit and step at k=0 in the same cycle -> cur_addr restored, no valid next cycle, cfg_err=1. loop_index=9 step with NUM_LOOPS=8 -> ignored, cfg_err=1.
- **Reset mid-walk:** assert reset low during step stream -> next cycle addr_out=0, valid=0, cfg_err=0. A step after reset release issues 0 with stride 0.
